// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel width and the line-fetch FSM state type.
package vga_pkg;
  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam bit H_POL   = 1'b0;
  localparam bit V_POL   = 1'b0;

  localparam int PIX_W   = 12;

  typedef enum logic [1:0] {IDLE, REQ, RECV} fetch_state_t;
endpackage

// File: rtl/line_ram.sv
// Two-line ping-pong pixel store: one write port, one registered read port.
// Logical address is {half, word}; half selects which line slot is used.
module line_ram #(
  parameter int LINE_LEN = 640,
  parameter int PIX_W    = 12,
  parameter int AW       = 11
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);
  localparam int DEPTH = 2 * LINE_LEN;
  localparam int RW    = $clog2(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];

  // Halves are packed back to back so depth is exactly two lines.
  function automatic logic [RW-1:0] row(input logic [AW-1:0] a);
    return RW'(a[AW-1] ? LINE_LEN : 0) + RW'(a[AW-2:0]);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[row(wr_addr)] <= wr_data;
    rd_data <= mem[row(rd_addr)];
  end
endmodule

// File: rtl/line_fetch.sv
// Scanline prefetcher: fetches line y+1 into a ping-pong RAM while line y is shown.
// Pixel/sync latency 1 clk; memory request held until rd_ack_i, data accepted whenever rd_valid_i.
module line_fetch #(
  parameter int H_DISP_LEN = vga_pkg::H_DISP,
  parameter int V_DISP_LEN = vga_pkg::V_DISP,
  parameter int H_POS_W    = 10,
  parameter int V_POS_W    = 9,
  parameter int PIX_W      = vga_pkg::PIX_W,
  parameter int ADDR_W     = 19,
  parameter int BASE_ADDR  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [H_POS_W-1:0] h_pos_i,
  input  logic [V_POS_W-1:0] v_pos_i,
  input  logic               h_disp_i,
  input  logic               v_disp_i,
  input  logic               h_sync_i,
  input  logic               v_sync_i,
  input  logic               h_disp_done_i,
  output logic               rd_req_o,
  output logic [ADDR_W-1:0]  rd_addr_o,
  input  logic               rd_ack_i,
  input  logic               rd_valid_i,
  input  logic [PIX_W-1:0]   rd_data_i,
  output logic [PIX_W-1:0]   rgb_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               underrun_o
);
  import vga_pkg::*;

  localparam int FL_W = $clog2(V_DISP_LEN + 1);

  fetch_state_t       state, state_nxt;
  logic [FL_W-1:0]    fetch_line_r;
  logic [H_POS_W-1:0] word_cnt;
  logic [1:0]         valid;
  logic               v_disp_q;
  logic               show_q;
  logic [PIX_W-1:0]   ram_q;
  logic               start, wr_en, last_word, pix_on, v_fall;
  logic               unused_ok;

  assign pix_on    = h_disp_i && v_disp_i;
  assign v_fall    = v_disp_q && !v_disp_i;
  assign wr_en     = (state == RECV) && rd_valid_i;
  assign last_word = wr_en && (word_cnt == H_POS_W'(H_DISP_LEN - 1));
  // In blanking only line 0 may be fetched, and only once per frame.
  assign start     = h_disp_done_i && (state == IDLE) &&
                     ((v_disp_i && (fetch_line_r < FL_W'(V_DISP_LEN))) ||
                      (!v_disp_i && (fetch_line_r == '0)));
  assign unused_ok = ^v_pos_i[V_POS_W-1:1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = REQ;
      REQ:     if (rd_ack_i)  state_nxt = RECV;
      RECV:    if (last_word) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fetch_line_r <= '0;
      word_cnt     <= '0;
      valid        <= '0;
      v_disp_q     <= 1'b0;
      rd_req_o     <= 1'b0;
      rd_addr_o    <= '0;
      show_q       <= 1'b0;
      underrun_o   <= 1'b0;
      hsync_o      <= 1'b0;
      vsync_o      <= 1'b0;
    end else begin
      state    <= state_nxt;
      v_disp_q <= v_disp_i;
      hsync_o  <= h_sync_i;
      vsync_o  <= v_sync_i;
      show_q   <= pix_on && valid[v_pos_i[0]];
      if (pix_on && !valid[v_pos_i[0]]) underrun_o <= 1'b1;

      if (start) begin
        valid[fetch_line_r[0]] <= 1'b0;
        rd_req_o  <= 1'b1;
        rd_addr_o <= ADDR_W'(BASE_ADDR + int'(fetch_line_r) * H_DISP_LEN);
      end else if ((state == REQ) && rd_ack_i) begin
        rd_req_o <= 1'b0;
        word_cnt <= '0;
      end

      if (wr_en)     word_cnt <= word_cnt + 1'b1;
      if (last_word) valid[fetch_line_r[0]] <= 1'b1;

      // Frame restart takes priority over a fetch finishing in the same cycle.
      if (v_fall)         fetch_line_r <= '0;
      else if (last_word) fetch_line_r <= fetch_line_r + 1'b1;
    end
  end

  line_ram #(
    .LINE_LEN (H_DISP_LEN),
    .PIX_W    (PIX_W),
    .AW       (H_POS_W + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({fetch_line_r[0], word_cnt}),
    .wr_data (rd_data_i),
    .rd_addr ({v_pos_i[0], h_pos_i}),
    .rd_data (ram_q)
  );

  assign rgb_o = show_q ? ram_q : '0;
endmodule

// File: tb/tb_line_fetch.sv
// Randomized scoreboard bench for line_fetch with a line-level reference model.
module tb_line_fetch;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    h_pos_i;
  logic [8:0]    v_pos_i;
  logic          h_disp_i, v_disp_i, h_sync_i, v_sync_i, h_disp_done_i;
  logic          rd_req_o;
  logic [18:0]   rd_addr_o;
  logic          rd_ack_i, rd_valid_i;
  logic [PW-1:0] rd_data_i;
  logic [PW-1:0] rgb_o;
  logic          hsync_o, vsync_o, underrun_o;

  line_fetch dut (
    .clk(clk), .rst(rst), .h_pos_i(h_pos_i), .v_pos_i(v_pos_i),
    .h_disp_i(h_disp_i), .v_disp_i(v_disp_i), .h_sync_i(h_sync_i), .v_sync_i(v_sync_i),
    .h_disp_done_i(h_disp_done_i), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o),
    .rd_ack_i(rd_ack_i), .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i),
    .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int tag; logic [PW-1:0] rgb; logic hs; logic vs; logic ur; } pix_t;
  pix_t pix_q[$];
  int   req_q[$];

  // Reference model: line contents, per-half validity, next line, sticky underrun.
  logic [PW-1:0] m_buf [2][H];
  bit            m_valid [2];
  int            m_fl   = 0;
  bit            m_ur   = 0;
  bit            m_busy = 0;

  // Memory responder controls.
  bit ack_hold = 0, ack_next = 0, streaming = 0;
  int abort_at = -1, done_cnt = 0, abort_cnt = 0, stray_cnt = 0;
  int s_addr = 0, s_idx = 0;

  function automatic logic [PW-1:0] mem_word(int a);
    return PW'((a * 37) ^ (a >> 9));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Framebuffer memory: acks a pending request, then streams a line with ~50% gaps.
  initial begin
    rd_ack_i = 1'b0; rd_valid_i = 1'b0; rd_data_i = '0;
    forever begin
      @(posedge clk); #1;
      rd_ack_i = 1'b0; rd_valid_i = 1'b0;
      if (ack_next) begin ack_next = 0; streaming = 1; s_idx = 0; end
      if (streaming) begin
        if ($urandom_range(0, 1) == 1) begin
          rd_valid_i = 1'b1;
          rd_data_i  = mem_word(s_addr + s_idx);
          s_idx++;
          if (s_idx == H) begin streaming = 0; done_cnt++; end
          else if (s_idx == abort_at) begin streaming = 0; abort_cnt++; end
        end
      end else if (stray_cnt > 0) begin
        rd_valid_i = 1'b1;
        rd_data_i  = PW'($urandom);
        stray_cnt--;
      end else if (rd_req_o && !ack_hold) begin
        rd_ack_i = 1'b1;
        s_addr   = int'(rd_addr_o);
        ack_next = 1;
      end
    end
  end

  // Monitor: requests checked on rising rd_req_o, pixels one clock after they were driven.
  pix_t me;
  bit   req_prev = 0;
  always @(negedge clk) begin
    if (rd_req_o && !req_prev) begin
      if (req_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_req: got addr %0d, required no request", rd_addr_o);
      end else begin
        chk("req_addr", 32'(rd_addr_o), 32'(req_q.pop_front()));
      end
    end
    req_prev = rd_req_o;
    if (pix_q.size() > 0 && pix_q[0].tag == cyc - 1) begin
      me = pix_q.pop_front();
      chk("rgb", 32'(rgb_o), 32'(me.rgb));
      chk("hsync", 32'(hsync_o), 32'(me.hs));
      chk("vsync", 32'(vsync_o), 32'(me.vs));
      chk("underrun", 32'(underrun_o), 32'(me.ur));
    end
  end

  task automatic pulse_done();
    if (!m_busy && ((v_disp_i && m_fl < V) || (!v_disp_i && m_fl == 0))) begin
      m_valid[m_fl % 2] = 0;
      req_q.push_back(m_fl * H);
      m_busy = 1;
    end
    @(posedge clk); #1 h_disp_done_i = 1'b1;
    @(posedge clk); #1 h_disp_done_i = 1'b0;
  endtask

  task automatic finish_fetch();
    int n0, t;
    n0 = done_cnt; t = 0;
    while (done_cnt == n0 && t < 5000) begin @(posedge clk); t++; end
    checks++;
    if (done_cnt == n0) begin
      failures++;
      $display("FAIL fetch_done: got no completed line in %0d cycles, required one", t);
    end else begin
      for (int i = 0; i < H; i++) m_buf[m_fl % 2][i] = mem_word(m_fl * H + i);
      m_valid[m_fl % 2] = 1;
      m_fl++;
    end
    m_busy = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic sweep(int line);
    for (int h = 0; h < H; h++) begin
      pix_t e;
      @(posedge clk); #1;
      h_disp_i = 1'b1; v_disp_i = 1'b1;
      v_pos_i  = 9'(line); h_pos_i = 10'(h);
      h_sync_i = 1'($urandom); v_sync_i = 1'($urandom);
      e.tag = cyc; e.hs = h_sync_i; e.vs = v_sync_i;
      if (m_valid[line % 2]) e.rgb = m_buf[line % 2][h];
      else begin e.rgb = '0; m_ur = 1; end
      e.ur = m_ur;
      pix_q.push_back(e);
    end
    @(posedge clk); #1 h_disp_i = 1'b0; h_pos_i = '0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, a0;
    rst = 1'b1; h_pos_i = '0; v_pos_i = '0; h_disp_i = 1'b0; v_disp_i = 1'b0;
    h_sync_i = 1'b1; v_sync_i = 1'b1; h_disp_done_i = 1'b0;
    m_valid[0] = 0; m_valid[1] = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_rgb", 32'(rgb_o), 0);
    chk("rst_hsync", 32'(hsync_o), 0);
    chk("rst_vsync", 32'(vsync_o), 0);
    chk("rst_underrun", 32'(underrun_o), 0);
    chk("rst_req", 32'(rd_req_o), 0);
    chk("rst_addr", 32'(rd_addr_o), 0);
    @(posedge clk); #1 rst = 1'b0; h_sync_i = 1'b0; v_sync_i = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle_req", 32'(rd_req_o), 0);

    // Blanking prefetch of line 0, then a second pulse must not fetch.
    pulse_done(); finish_fetch();
    pulse_done();
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("blank_second_req", 32'(rd_req_o), 0);

    // Display lines, fetching y+1 at the end of each; line 6 lands in half 0.
    @(posedge clk); #1 v_disp_i = 1'b1;
    sweep(0);
    for (int y = 0; y < 6; y++) begin
      pulse_done(); finish_fetch();
      if (y == 0) sweep(1);
    end
    stray_cnt = 12;
    repeat (20) @(posedge clk);
    sweep(6);
    sweep(5);

    // New frame; then starve the line-1 fetch so line 1 underruns.
    @(posedge clk); #1 v_disp_i = 1'b0;
    m_fl = 0;
    repeat (2) @(posedge clk);
    pulse_done(); finish_fetch();
    @(posedge clk); #1 v_disp_i = 1'b1;
    sweep(0);
    ack_hold = 1;
    pulse_done();
    sweep(1);
    @(negedge clk);
    chk("req_held", 32'(rd_req_o), 1);
    chk("underrun_set", 32'(underrun_o), 1);
    ack_hold = 0;
    finish_fetch();
    sweep(1);

    // Reset in the middle of receiving line 2.
    abort_at = 100;
    pulse_done();
    a0 = abort_cnt; t = 0;
    while (abort_cnt == a0 && t < 5000) begin @(posedge clk); t++; end
    chk("abort_reached", 32'(abort_cnt - a0), 1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    m_valid[0] = 0; m_valid[1] = 0; m_fl = 0; m_ur = 0; m_busy = 0; abort_at = -1;
    stray_cnt = 20;
    @(negedge clk);
    chk("midrst_req", 32'(rd_req_o), 0);
    chk("midrst_underrun", 32'(underrun_o), 0);
    repeat (25) @(posedge clk);
    sweep(0);
    sweep(1);
    pulse_done(); finish_fetch();
    sweep(0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("req_q_drained", 32'(req_q.size()), 0);
    chk("pix_q_drained", 32'(pix_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/line_fetch.md
# line_fetch

Scanline prefetcher between the framebuffer memory port and the VGA pins. It sits directly downstream of the horizontal and vertical sync counters. While line y is being displayed, it fetches line y+1 from memory into a two-line ping-pong RAM. It then drives registered RGB, hsync and vsync, with the syncs delayed to match pixel latency.

## Interface
Parameters:
- H_DISP_LEN, 640, active pixels per line
- V_DISP_LEN, 480, active lines per frame
- H_POS_W, 10, width of horizontal position input
- V_POS_W, 9, width of vertical position input
- PIX_W, 12, pixel width (4:4:4 RGB)
- ADDR_W, 19, memory word address width
- BASE_ADDR, 0, word address of framebuffer line 0

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- h_pos_i  in  H_POS_W  horizontal position; 0 outside active area
- v_pos_i  in  V_POS_W  vertical position; 0 outside active area
- h_disp_i  in  1  horizontal active area
- v_disp_i  in  1  vertical active area
- h_sync_i  in  1  horizontal sync, polarity already applied
- v_sync_i  in  1  vertical sync, polarity already applied
- h_disp_done_i  in  1  one-cycle pulse at end of active pixels of a line
- rd_req_o  out  1  line read request
- rd_addr_o  out  ADDR_W  start word address of requested line
- rd_ack_i  in  1  request accepted
- rd_valid_i  in  1  read data word valid
- rd_data_i  in  PIX_W  read data word, in address order
- rgb_o  out  PIX_W  pixel output
- hsync_o  out  1  delayed h_sync_i
- vsync_o  out  1  delayed v_sync_i
- underrun_o  out  1  sticky; a displayed line was not yet fetched

## Operation
- Line y is stored in buffer half y[0]. Write address = {fetch_line[0], word_cnt}. Read address = {v_pos_i[0], h_pos_i}.
- fetch_line_r, range 0..V_DISP_LEN, is the next line to fetch.
  - Cleared on the falling edge of v_disp_i, detected against a registered copy of v_disp_i.
  - Incremented when a fetch completes.
- Fetch start condition: h_disp_done_i is high, the FSM is in IDLE, and one of the following holds:
  - v_disp_i is high and fetch_line_r < V_DISP_LEN; or
  - v_disp_i is low and fetch_line_r == 0.
  Result: exactly one prefetch of line 0 occurs during vertical blanking.
- FSM states:
  - IDLE: on the start condition, clear valid[fetch_line_r[0]] and go to REQ.
  - REQ: rd_req_o=1 and rd_addr_o=BASE_ADDR+fetch_line_r*H_DISP_LEN (truncated to ADDR_W), both held stable. On rd_ack_i, go to RECV with word_cnt=0.
  - RECV: each rd_valid_i writes one word and increments word_cnt. On the word with word_cnt==H_DISP_LEN-1, set valid[half], increment fetch_line_r, and go to IDLE.
- rd_valid_i outside RECV is ignored; nothing is written.
- The fetch for line y+1 never writes the half being displayed, because it targets the opposite parity.
- Pixel output: rgb_o = (h_disp_i && v_disp_i && valid[v_pos_i[0]]) ? ram data : 0.
- underrun_o sets when h_disp_i && v_disp_i && !valid[v_pos_i[0]]. It clears only on rst.

## Timing
- Reset values: rd_req_o=0, rd_addr_o=0, rgb_o=0, hsync_o=0, vsync_o=0, underrun_o=0. FSM is IDLE, fetch_line_r=0, both valid bits are 0.
- Pixel path latency is 1 clk. The RAM read is synchronous, and the blank/select decision is registered alongside it.
- hsync_o and vsync_o are registered once, so sync stays aligned with rgb_o.
- Outputs are updated every clk. Counter inputs hold between pixel ticks, so pixel-rate operation needs no enable.
- Handshake:
  - rd_req_o may assert in the cycle after the start condition.
  - The request is accepted in a cycle with rd_req_o && rd_ack_i. rd_req_o deasserts in the following cycle.
  - rd_valid_i may arrive from the cycle after acceptance, with any gaps.
- A fetch-complete in the same cycle as the v_disp_i falling edge: the clear wins.
- A start condition in the same cycle as the completion of the previous fetch: the start is ignored, because the FSM is not yet in IDLE.
- rst mid-fetch: abandon immediately and drop any outstanding data. Memory must tolerate an abandoned request.
- Fetch budget per line = H blanking + H_DISP_LEN clocks (pixel-tick periods × divider). Exceeding it produces an underrun.

## Structure
- vga_pkg holds:
  - timing constants: H/V display, porch and sync lengths, and polarity;
  - PIX_W;
  - the fetch FSM state enum (IDLE, REQ, RECV).
- Sub-module line_ram:
  - simple dual-port RAM, 2*H_DISP_LEN × PIX_W;
  - one write port, one registered read port, same clk.

## Test plan
- Reset, then idle: all outputs 0, no rd_req_o.
- Line fetch:
  - Stimulus: v_disp_i=0, h_disp_done_i pulse.
  - Response: rd_req_o with rd_addr_o=0; after ack and 640 words, valid[0]=1 and fetch_line_r=1.
  - A second pulse in blanking issues no request.
- Address and parity:
  - Stimulus: display line 5, h_disp_done_i.
  - Response: rd_addr_o=6*640=3840; data lands in half 0.
  - During line 6, pixel h_pos_i=10 appears on rgb_o 1 clk later, with hsync_o/vsync_o delayed 1 clk.
- Gappy stream: rd_valid_i toggles 50% → exactly 640 writes, correct order; a stray rd_valid_i in IDLE writes nothing.
- Underrun: withhold rd_ack_i past the start of line 1 → rgb_o=0 throughout line 1, underrun_o=1 and sticky until rst.
- Reset mid-RECV after 100 words → FSM IDLE, valid bits 0, rd_req_o=0; further rd_valid_i ignored.
